// File: rtl/alu_mul_sequencer.sv
// Unsigned 16x16->32 shift-and-add multiplier that drives an external 16-bit ALU.
// Each 32-bit accumulate is split into a low ADD and a high ADC that uses the ALU's registered carry.
module alu_mul_sequencer #(
  parameter bit         EARLY_EXIT = 1'b1,
  parameter logic [4:0] SEL_IDLE   = 5'b10000,
  parameter logic [4:0] SEL_ADD    = 5'b10100,
  parameter logic [4:0] SEL_ADC    = 5'b10101
) (
  input  logic        clk,
  input  logic        rst_n,
  // start_i is sampled only in IDLE (no queueing); done_o pulses for one
  // cycle and product_o is valid from that cycle until the next done_o.
  input  logic        start_i,
  input  logic [15:0] multiplicand_i,
  input  logic [15:0] multiplier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic [4:0]  alu_fun_sel_o,
  output logic        alu_wf_o,
  input  logic [15:0] alu_out_i,
  input  logic [3:0]  alu_flags_i,
  output logic        ovf_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXAM   = 2'd1,
    ADD_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;
  logic        adc_q, adc_d;
  logic        ovf_q, ovf_d;
  logic        do_shift;
  logic        last_step;
  logic        unused_flags;

  // Only the carry flag matters here; the other flags are the ALU's business.
  assign unused_flags = ^{alu_flags_i[3], alu_flags_i[1:0]};

  assign last_step = (cnt_q == 4'd15) ||
                     (EARLY_EXIT && (mplier_q[15:1] == 15'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= 32'd0;
      mplier_q  <= 16'd0;
      acc_q     <= 32'd0;
      cnt_q     <= 4'd0;
      product_q <= 32'd0;
      adc_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      adc_q     <= adc_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    adc_d     = 1'b0;
    ovf_d     = ovf_q;
    do_shift  = 1'b0;

    // The ADC carry-out is only visible in the flags one cycle after ADD_HI.
    if (adc_q && alu_flags_i[2]) ovf_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = {16'd0, multiplicand_i};
          mplier_d = multiplier_i;
          acc_d    = 32'd0;
          cnt_d    = 4'd0;
          ovf_d    = 1'b0;
          state_d  = EXAM;
        end
      end
      EXAM: begin
        if (mplier_q[0]) begin
          acc_d[15:0] = alu_out_i;
          state_d     = ADD_HI;
        end else begin
          do_shift = 1'b1;
        end
      end
      ADD_HI: begin
        acc_d[31:16] = alu_out_i;
        adc_d        = 1'b1;
        do_shift     = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The shift step lives on the leaving edge; product captures the final acc_d.
    if (do_shift) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 4'd1;
      if (last_step) begin
        state_d   = DONE;
        product_d = acc_d;
      end else begin
        state_d = EXAM;
      end
    end
  end

  always_comb begin
    alu_a_o       = 16'd0;
    alu_b_o       = 16'd0;
    alu_fun_sel_o = SEL_IDLE;
    alu_wf_o      = 1'b0;
    case (state_q)
      EXAM: begin
        if (mplier_q[0]) begin
          alu_a_o       = acc_q[15:0];
          alu_b_o       = mcand_q[15:0];
          alu_fun_sel_o = SEL_ADD;
          alu_wf_o      = 1'b1;
        end
      end
      ADD_HI: begin
        alu_a_o       = acc_q[31:16];
        alu_b_o       = mcand_q[31:16];
        alu_fun_sel_o = SEL_ADC;
        alu_wf_o      = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign product_o = product_q;
  assign ovf_o     = ovf_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench: two sequencers (early exit on/off) share stimulus, each driving its own ALU model.
module tb_alu_mul_sequencer;

  localparam logic [4:0] SEL_IDLE = 5'b10000;
  localparam logic [4:0] SEL_ADD  = 5'b10100;
  localparam logic [4:0] SEL_ADC  = 5'b10101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] multiplicand = 16'd0;
  logic [15:0] multiplier = 16'd0;

  logic        busy1, done1, wf1, ovf1;
  logic [31:0] product1;
  logic [15:0] a1, b1;
  logic [4:0]  sel1;
  logic [1:0]  state1;
  logic [16:0] res1;
  logic [3:0]  flags1;

  logic        busy2, done2, wf2, ovf2;
  logic [31:0] product2;
  logic [15:0] a2, b2;
  logic [4:0]  sel2;
  logic [1:0]  state2;
  logic [16:0] res2;
  logic [3:0]  flags2;

  int n_pass = 0;
  int n_checks = 0;
  int add_cnt1, adc_cnt1, done_cnt1, add_cnt2, adc_cnt2, done_cnt2;
  logic c_exp1, c_exp2;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .multiplicand_i(multiplicand), .multiplier_i(multiplier),
    .busy_o(busy1), .done_o(done1), .product_o(product1),
    .alu_a_o(a1), .alu_b_o(b1), .alu_fun_sel_o(sel1), .alu_wf_o(wf1),
    .alu_out_i(res1[15:0]), .alu_flags_i(flags1), .ovf_o(ovf1), .state_o(state1)
  );

  alu_mul_sequencer #(.EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .multiplicand_i(multiplicand), .multiplier_i(multiplier),
    .busy_o(busy2), .done_o(done2), .product_o(product2),
    .alu_a_o(a2), .alu_b_o(b2), .alu_fun_sel_o(sel2), .alu_wf_o(wf2),
    .alu_out_i(res2[15:0]), .alu_flags_i(flags2), .ovf_o(ovf2), .state_o(state2)
  );

  function automatic logic [16:0] alu_f(input logic [4:0] sel, input logic [15:0] a,
                                        input logic [15:0] b, input logic c);
    if (sel == SEL_ADD) return {1'b0, a} + {1'b0, b};
    if (sel == SEL_ADC) return {1'b0, a} + {1'b0, b} + {16'd0, c};
    return {1'b0, a};
  endfunction

  assign res1 = alu_f(sel1, a1, b1, flags1[2]);
  assign res2 = alu_f(sel2, a2, b2, flags2[2]);

  // ALU flag registers {Z,C,N,O}
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags1 <= 4'd0;
      flags2 <= 4'd0;
    end else begin
      if (wf1) flags1 <= {res1[15:0] == 16'd0, res1[16], res1[15],
                          (a1[15] == b1[15]) && (res1[15] != a1[15])};
      if (wf2) flags2 <= {res2[15:0] == 16'd0, res2[16], res2[15],
                          (a2[15] == b2[15]) && (res2[15] != a2[15])};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ALU-side monitor: counts add cycles and checks the carry chain.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wf1 && sel1 == SEL_ADD) begin
        add_cnt1++;
        c_exp1 = res1[16];
      end
      if (wf1 && sel1 == SEL_ADC) begin
        adc_cnt1++;
        check("early_adc_carry_in", {31'd0, flags1[2]}, {31'd0, c_exp1});
        check("early_adc_carry_out", {31'd0, res1[16]}, 32'd0);
      end
      if (done1) done_cnt1++;
      if (wf2 && sel2 == SEL_ADD) begin
        add_cnt2++;
        c_exp2 = res2[16];
      end
      if (wf2 && sel2 == SEL_ADC) begin
        adc_cnt2++;
        check("full_adc_carry_in", {31'd0, flags2[2]}, {31'd0, c_exp2});
        check("full_adc_carry_out", {31'd0, res2[16]}, 32'd0);
      end
      if (done2) done_cnt2++;
    end
  end

  task automatic run_mul(input logic [15:0] mc, input logic [15:0] mp, input logic [31:0] exp_p,
                         input int lat1, input int lat2, input int adds, input bit inject,
                         input string tag);
    int got1, got2;
    got1 = -1;
    got2 = -1;
    @(posedge clk); #1;
    multiplicand = mc;
    multiplier = mp;
    start = 1'b1;
    add_cnt1 = 0; adc_cnt1 = 0; done_cnt1 = 0;
    add_cnt2 = 0; adc_cnt2 = 0; done_cnt2 = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, {31'd0, busy1}, 32'd1);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inject && n == 3) begin
        multiplicand = 16'hFFFF;
        multiplier = 16'hFFFF;
        start = 1'b1;
      end
      if (done1 && got1 < 0) begin
        got1 = n;
        check({tag, "_early_product"}, product1, exp_p);
        check({tag, "_early_busy_in_done"}, {31'd0, busy1}, 32'd1);
      end
      if (done2 && got2 < 0) begin
        got2 = n;
        check({tag, "_full_product"}, product2, exp_p);
      end
      if (got1 >= 0 && got2 >= 0) break;
    end
    check({tag, "_early_latency"}, got1, lat1);
    check({tag, "_full_latency"}, got2, lat2);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_one_cycle"}, {31'd0, done2}, 32'd0);
    check({tag, "_idle_after"}, {30'd0, busy1, busy2}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_early_product_held"}, product1, exp_p);
    check({tag, "_full_product_held"}, product2, exp_p);
    check({tag, "_done_pulses"}, {16'(done_cnt1), 16'(done_cnt2)}, {16'd1, 16'd1});
    check({tag, "_early_add_pairs"}, {16'(add_cnt1), 16'(adc_cnt1)}, {16'(adds), 16'(adds)});
    check({tag, "_full_add_pairs"}, {16'(add_cnt2), 16'(adc_cnt2)}, {16'(adds), 16'(adds)});
    check({tag, "_ovf"}, {30'd0, ovf1, ovf2}, 32'd0);
  endtask

  initial begin
    int found;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy_done", {30'd0, busy1, done1}, 32'd0);
    check("reset_product", product1, 32'd0);
    check("reset_alu_ab", {a1, b1}, 32'd0);
    check("reset_alu_sel_wf", {26'd0, sel1, wf1}, {26'd0, SEL_IDLE, 1'b0});
    check("reset_state", {30'd0, state1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1..T4
    run_mul(16'd5,     16'd3,     32'h0000000F, 4,  18, 2,  1'b0, "t1");
    run_mul(16'hFFFF,  16'hFFFF,  32'hFFFE0001, 32, 32, 16, 1'b0, "t2");
    run_mul(16'h1234,  16'h0000,  32'h00000000, 1,  16, 0,  1'b0, "t3");
    run_mul(16'h8000,  16'h8000,  32'h40000000, 17, 17, 1,  1'b0, "t4");

    // T5: asynchronous reset while the first ADC is on the bus
    @(posedge clk); #1;
    multiplicand = 16'hFFFF;
    multiplier = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (sel1 == SEL_ADC) begin
        found = 1;
        break;
      end
    end
    check("t5_reached_add_hi", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy_done_wf", {28'd0, busy1, done1, wf1, busy2}, 32'd0);
    check("t5_rst_product", product1, 32'd0);
    check("t5_rst_full_product", product2, 32'd0);
    check("t5_rst_sel", {27'd0, sel1}, {27'd0, SEL_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(16'd7, 16'd9, 32'h0000003F, 6, 18, 2, 1'b0, "t5");

    // T6: a second Start with new operands while busy is ignored
    run_mul(16'h1234, 16'h0101, 32'h00124634, 11, 18, 2, 1'b1, "t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
